sevenseg_scan_decoder: RTL

Reads a time-multiplexed seven-segment display bus (one-hot digit strobe plus shared segment lines) and reconstructs the displayed hex value, one nibble per digit.
- Performs the inverse of the team's hex-to-segment encoding.
- Used as a loopback checker and readback path for the display driver, so test logic and the top level can confirm what the panel actually shows.
- Samples each digit only after its strobe and segments have been stable for a set time, flags illegal patterns, and publishes a complete frame atomically.

---
 rtl/sevenseg_scan_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_decoder.sv
// Reconstructs hex digits from a time-multiplexed seven-segment bus and publishes whole frames.
// Define SEG_ACTIVE_LOW_EN for common-anode boards with active-low segment and anode lines.
module sevenseg_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_done
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntPre = CntW'(SETTLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AllSeen = {NUM_DIGITS{1'b1}};

  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;

`ifdef SEG_ACTIVE_LOW_EN
  assign w_seg = ~seg_in;
  assign w_an  = ~an_in;
`else
  assign w_seg = seg_in;
  assign w_an  = an_in;
`endif

  logic [6:0]              r_seg_prev;
  logic [NUM_DIGITS-1:0]   r_an_prev;
  logic [CntW-1:0]         r_cnt;
  logic                    r_captured;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic                    r_valid;
  logic [NUM_DIGITS-1:0]   r_digit_err;
  logic                    r_frame_done;

  logic                    w_an_changed;
  logic                    w_changed;
  logic                    w_onehot;
  logic                    w_capture;
  logic [3:0]              w_nib;
  logic                    w_illegal;
  logic [CntW-1:0]         w_cnt_next;
  logic                    w_captured_next;
  logic [NUM_DIGITS-1:0]   w_seen_base;
  logic [NUM_DIGITS-1:0]   w_err_base;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  logic [NUM_DIGITS-1:0]   w_err_next;
  logic [4*NUM_DIGITS-1:0] w_shadow_next;
  logic                    w_pend_next;

  assign w_an_changed = (w_an != r_an_prev);
  assign w_changed    = w_an_changed || (w_seg != r_seg_prev);
  assign w_onehot     = (w_an != '0) && ((w_an & (w_an - NUM_DIGITS'(1))) == '0);
  // Fires on the single edge where the count steps from SETTLE_CYCLES-1 to SETTLE_CYCLES.
  assign w_capture    = !w_changed && (r_cnt == CntPre) && w_onehot && !r_captured;

  always_comb begin
    w_nib     = 4'h0;
    w_illegal = 1'b0;
    case (w_seg)
      7'b0111111: w_nib = 4'h0;
      7'b0000110: w_nib = 4'h1;
      7'b1011011: w_nib = 4'h2;
      7'b1001111: w_nib = 4'h3;
      7'b1100110: w_nib = 4'h4;
      7'b1101101: w_nib = 4'h5;
      7'b1111101: w_nib = 4'h6;
      7'b0000111: w_nib = 4'h7;
      7'b1111111: w_nib = 4'h8;
      7'b1101111: w_nib = 4'h9;
      7'b1110111: w_nib = 4'hA;
      7'b1111100: w_nib = 4'hB;
      7'b0111001: w_nib = 4'hC;
      7'b1011110: w_nib = 4'hD;
      7'b1111001: w_nib = 4'hE;
      7'b1110001: w_nib = 4'hF;
      default:    w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_changed) begin
      w_cnt_next = '0;
    end else if (r_cnt != CntMax) begin
      w_cnt_next = r_cnt + CntW'(1);
    end

    w_captured_next = r_captured;
    if (w_an_changed) begin
      w_captured_next = 1'b0;
    end else if (w_capture) begin
      w_captured_next = 1'b1;
    end

    // While a completion is pending the old masks are retired; any capture starts the new frame.
    w_seen_base   = r_pend ? '0 : r_seen;
    w_err_base    = r_pend ? '0 : r_err;
    w_seen_next   = w_seen_base;
    w_err_next    = w_err_base;
    w_shadow_next = r_shadow;
    if (w_capture) begin
      w_seen_next = w_seen_base | w_an;
      w_err_next  = w_illegal ? (w_err_base | w_an) : (w_err_base & ~w_an);
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (w_an[i]) begin
          w_shadow_next[4*i +: 4] = w_nib;
        end
      end
    end
    w_pend_next = w_capture && (w_seen_next == AllSeen);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_prev   <= '0;
      r_an_prev    <= '0;
      r_cnt        <= '0;
      r_captured   <= 1'b0;
      r_shadow     <= '0;
      r_seen       <= '0;
      r_err        <= '0;
      r_pend       <= 1'b0;
      r_value      <= '0;
      r_valid      <= 1'b0;
      r_digit_err  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_prev   <= w_seg;
      r_an_prev    <= w_an;
      r_cnt        <= w_cnt_next;
      r_captured   <= w_captured_next;
      r_shadow     <= w_shadow_next;
      r_seen       <= w_seen_next;
      r_err        <= w_err_next;
      r_pend       <= w_pend_next;
      r_frame_done <= r_pend;
      if (r_pend) begin
        r_digit_err <= r_err;
        if (r_err == '0) begin
          r_value <= r_shadow;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign value      = r_value;
  assign valid      = r_valid;
  assign digit_err  = r_digit_err;
  assign frame_done = r_frame_done;

endmodule
